// File: rtl/joy_serial_reader.sv
// Serial reader for the joystick shift-register chain: drives joy_clk/joy_load_n,
// shifts NJOY*JOY_BITS bits in and publishes a frame-consistent parallel word.
module joy_serial_reader #(
  parameter int CLK_DIV  = 4,
  parameter int NJOY     = 2,
  parameter int JOY_BITS = 12,
  parameter int GAP      = 64,
  parameter int INVERT   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     passthru,
  output logic                     joy_clk,
  output logic                     joy_load_n,
  input  logic                     joy_data,
  input  logic                     xjoy_clk,
  input  logic                     xjoy_load_n,
  output logic                     xjoy_data,
  output logic [NJOY*JOY_BITS-1:0] joy_out,
  output logic                     frame_valid
);

  localparam int N      = NJOY * JOY_BITS;
  localparam int PH_MAX = (2 * CLK_DIV > GAP) ? 2 * CLK_DIV : GAP;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam int BIT_W  = (N > 1) ? $clog2(N) : 1;

  localparam logic [PH_W-1:0]  PH_LOAD_END = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF_END = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_GAP_END  = PH_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE,
    S_WAIT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic              w_sample;
  logic              w_joy_clk_d, w_load_n_d, w_publish;
  logic              r_joy_clk, r_load_n, r_frame_valid;
  logic              r_sync_p0, r_sync_p1;
  logic [N-1:0]      r_shift, r_joy_out;

  // Pad lines are active-low on the boards, so the chain polarity is selectable.
  function automatic logic f_polarity(input logic b);
    return (INVERT != 0) ? ~b : b;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous chain data.
  always_ff @(posedge clk) begin
    r_sync_p0 <= joy_data;
    r_sync_p1 <= r_sync_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_bit         <= '0;
      r_joy_clk     <= 1'b0;
      r_load_n      <= 1'b1;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_bit         <= w_bit_nxt;
      r_joy_clk     <= w_joy_clk_d;
      r_load_n      <= w_load_n_d;
      r_frame_valid <= w_publish;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase + 1'b1;
    w_bit_nxt   = r_bit;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        if (!passthru) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (r_phase == PH_LOAD_END) begin
          w_state_nxt = S_SHIFT_LO;
          w_phase_nxt = '0;
          w_bit_nxt   = '0;
        end
      end
      S_SHIFT_LO: begin
        if (r_phase == PH_HALF_END) begin
          w_sample    = 1'b1;
          w_state_nxt = S_SHIFT_HI;
          w_phase_nxt = '0;
        end
      end
      S_SHIFT_HI: begin
        if (r_phase == PH_HALF_END) begin
          w_phase_nxt = '0;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SHIFT_LO;
            w_bit_nxt   = r_bit + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_WAIT;
        w_phase_nxt = '0;
      end
      S_WAIT: begin
        if (r_phase == PH_GAP_END) begin
          w_state_nxt = S_LOAD;
          w_phase_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
      end
    endcase
    // Pass-through abandons any frame in flight; nothing partial is ever published.
    if (passthru) begin
      w_state_nxt = S_IDLE;
      w_phase_nxt = '0;
      w_bit_nxt   = '0;
      w_sample    = 1'b0;
    end
  end

  // Outputs decode the next state so joy_clk/joy_load_n leave a flop, glitch-free.
  always_comb begin
    w_joy_clk_d = (w_state_nxt == S_SHIFT_HI);
    w_load_n_d  = (w_state_nxt != S_LOAD);
    w_publish   = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_joy_out <= '0;
    end else begin
      if (w_sample) r_shift[r_bit] <= f_polarity(r_sync_p1);
      if (w_publish) r_joy_out <= r_shift;
    end
  end

  assign joy_clk     = passthru ? xjoy_clk : r_joy_clk;
  assign joy_load_n  = passthru ? xjoy_load_n : r_load_n;
  assign xjoy_data   = joy_data;
  assign joy_out     = r_joy_out;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench for joy_serial_reader: default build checked cycle-by-cycle against a frame
// timeline model, plus a small-parameter build checked for period and value.
module tb_joy_serial_reader;

  localparam int CD       = 4;
  localparam int N        = 24;
  localparam int GP       = 64;
  localparam int T_DONE   = 2 * CD * (N + 1);   // 200 cycles from LOAD entry to DONE
  localparam int T_PERIOD = T_DONE + 1 + GP;    // 265

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, passthru = 1'b0, xjoy_clk = 1'b0, xjoy_load_n = 1'b1;
  logic          joy_clk, joy_load_n, joy_data, xjoy_data, frame_valid;
  logic [N-1:0]  joy_out;
  logic          pt_b = 1'b0, xclk_b = 1'b0, xload_b = 1'b1;
  logic          joy_clk_b, joy_load_n_b, joy_data_b, xjoy_data_b, frame_valid_b;
  logic [7:0]    joy_out_b;

  joy_serial_reader #(.CLK_DIV(4), .NJOY(2), .JOY_BITS(12), .GAP(64), .INVERT(1)) dut_a (
    .clk(clk), .reset(reset), .passthru(passthru),
    .joy_clk(joy_clk), .joy_load_n(joy_load_n), .joy_data(joy_data),
    .xjoy_clk(xjoy_clk), .xjoy_load_n(xjoy_load_n), .xjoy_data(xjoy_data),
    .joy_out(joy_out), .frame_valid(frame_valid));

  joy_serial_reader #(.CLK_DIV(2), .NJOY(1), .JOY_BITS(8), .GAP(1), .INVERT(0)) dut_b (
    .clk(clk), .reset(reset), .passthru(pt_b),
    .joy_clk(joy_clk_b), .joy_load_n(joy_load_n_b), .joy_data(joy_data_b),
    .xjoy_clk(xclk_b), .xjoy_load_n(xload_b), .xjoy_data(xjoy_data_b),
    .joy_out(joy_out_b), .frame_valid(frame_valid_b));

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // 74HC165-style chain: parallel load while load_n low, shift toward bit 0 on joy_clk rise.
  logic [N-1:0] load_val = 24'hA5A5A5, chain_a = '1;
  logic         jq_a = 1'b0;
  always @(posedge clk) begin
    if (!joy_load_n) chain_a <= load_val;
    else if (joy_clk && !jq_a) chain_a <= {1'b1, chain_a[N-1:1]};
    jq_a <= joy_clk;
  end
  assign joy_data = chain_a[0];

  logic [7:0] load_b = 8'h3C, chain_b = '1;
  logic       jq_b = 1'b0;
  always @(posedge clk) begin
    if (!joy_load_n_b) chain_b <= load_b;
    else if (joy_clk_b && !jq_b) chain_b <= {1'b1, chain_b[7:1]};
    jq_b <= joy_clk_b;
  end
  assign joy_data_b = chain_b[0];

  // Frame timeline model: m_t counts cycles since LOAD entry of the running frame.
  logic         m_active = 1'b0, m_valid = 1'b0, chk_en = 1'b0;
  int           m_t = 0;
  logic [N-1:0] m_val = '0, m_out = '0;
  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0; m_t <= 0; m_valid <= 1'b0; m_out <= '0; chk_en <= 1'b1;
    end else if (passthru) begin
      m_active <= 1'b0; m_valid <= 1'b0;
    end else if (!m_active) begin
      m_active <= 1'b1; m_t <= 0; m_val <= load_val; m_valid <= 1'b0;
    end else if (m_t + 1 == T_PERIOD) begin
      m_t <= 0; m_val <= load_val; m_valid <= 1'b0;
    end else begin
      m_t     <= m_t + 1;
      m_valid <= (m_t + 1 == T_DONE);
      if (m_t + 1 == T_DONE) m_out <= ~m_val;
    end
  end

  function automatic logic f_exp_jclk();
    if (!m_active) return 1'b0;
    return (m_t >= 2 * CD) && (m_t < T_DONE) && (((m_t - 2 * CD) % (2 * CD)) >= CD);
  endfunction

  function automatic logic f_exp_load_n();
    if (!m_active) return 1'b1;
    return !(m_t < 2 * CD);
  endfunction

  int a_pulses = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("frame_valid", 32'(frame_valid), 32'(m_valid));
      chk("joy_out", 32'(joy_out), 32'(m_out));
      chk("xjoy_data", 32'(xjoy_data), 32'(joy_data));
      if (passthru) begin
        chk("pt_joy_clk", 32'(joy_clk), 32'(xjoy_clk));
        chk("pt_joy_load_n", 32'(joy_load_n), 32'(xjoy_load_n));
      end else begin
        chk("joy_clk", 32'(joy_clk), 32'(f_exp_jclk()));
        chk("joy_load_n", 32'(joy_load_n), 32'(f_exp_load_n()));
      end
      if (frame_valid) a_pulses++;
    end
  end

  // Small build: first pulse 36+1 edges after release, then every 4*9+1+1 = 38 cycles.
  int   b_rel = 0, b_last = 0, b_pulses = 0;
  logic b_have = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      b_rel  = cyc + 1;
      b_have = 1'b0;
    end else if (chk_en) begin
      chk("b_xjoy_data", 32'(xjoy_data_b), 32'(joy_data_b));
      if (frame_valid_b) begin
        b_pulses++;
        if (b_have) chk("b_period", cyc - b_last, 38);
        else chk("b_first_delay", cyc - b_rel, 37);
        chk("b_value", 32'(joy_out_b), 32'h3C);
        b_last = cyc;
        b_have = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic goto_cyc(input int c);
    do begin
      @(posedge clk);
      #2;
    end while (cyc < c);
  endtask

  task automatic wait_pulse(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (frame_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL pulse_timeout: no frame_valid within %0d cycles", budget);
      at = cyc;
    end
  endtask

  int p, prev, rel, pc;
  logic [N-1:0] saved;

  initial begin
    // Reset: five edges with reset high, then the first frame.
    repeat (5) step();
    chk("rst_joy_out", 32'(joy_out), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_joy_clk", 32'(joy_clk), 32'h0);
    chk("rst_joy_load_n", 32'(joy_load_n), 32'h1);
    reset = 1'b0;
    rel = cyc;
    // The pulse occupies the 202nd cycle after release (1 IDLE + 200 + 1).
    wait_pulse(400, p);
    chk("first_pulse_delay", p - rel, 201);
    chk("first_value", 32'(joy_out), 32'h5A5A5A);

    // Back-to-back frames with bit-order patterns loaded during WAIT.
    step(); load_val = 24'hFFFFFE;
    prev = p; wait_pulse(400, p);
    chk("period_bit0", p - prev, 265);
    chk("bit0_value", 32'(joy_out), 32'h000001);
    step(); load_val = 24'h7FFFFF;
    prev = p; wait_pulse(400, p);
    chk("period_bit23", p - prev, 265);
    chk("bit23_value", 32'(joy_out), 32'h800000);
    step(); load_val = 24'h123456;
    prev = p; wait_pulse(400, p);
    chk("period_mixed", p - prev, 265);
    chk("mixed_value", 32'(joy_out), 32'hEDCBA9);

    // Pass-through during bit 10 (LOAD at p+65, bit 10 low phase from p+153).
    step(); load_val = 24'h0F0F0F;
    goto_cyc(p + 155);
    saved = joy_out;
    pc = a_pulses;
    passthru = 1'b1;
    for (int i = 0; i < 50; i++) begin
      xjoy_clk    = ~xjoy_clk;
      xjoy_load_n = ((i % 10) != 3);
      #1;
      chk("pt_zero_delay_clk", 32'(joy_clk), 32'(xjoy_clk));
      chk("pt_zero_delay_load", 32'(joy_load_n), 32'(xjoy_load_n));
      step();
    end
    passthru    = 1'b0;
    xjoy_load_n = 1'b1;
    rel = cyc;
    chk("pt_no_pulse", a_pulses - pc, 0);
    chk("pt_joy_out_held", 32'(joy_out), 32'(saved));
    wait_pulse(400, p);
    chk("pt_resume_delay", p - rel, 201);
    chk("pt_resume_value", 32'(joy_out), 32'hF0F0F0);

    // Reset in the high phase of bit 5 (LOAD at p+65, bit 5 high from p+117).
    step(); load_val = 24'h00FF00;
    goto_cyc(p + 118);
    pc = a_pulses;
    reset = 1'b1;
    repeat (3) step();
    chk("midrst_joy_out", 32'(joy_out), 32'h0);
    chk("midrst_frame_valid", 32'(frame_valid), 32'h0);
    reset = 1'b0;
    rel = cyc;
    wait_pulse(400, p);
    chk("midrst_delay", p - rel, 201);
    chk("midrst_single_pulse", a_pulses - pc, 1);
    chk("midrst_value", 32'(joy_out), 32'hFF00FF);

    step();
    chk("a_pulse_total", a_pulses, 6);
    chk("b_pulses_seen", 32'(b_pulses >= 10), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
